// File: rtl/redirect_pkg.sv
// rtl/redirect_pkg.sv - shared state and redirect-source encodings for redirect control
package redirect_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam logic [1:0] SRC_NONE = 2'd0;
    localparam logic [1:0] SRC_EX1  = 2'd1;
    localparam logic [1:0] SRC_EX2  = 2'd2;
    localparam logic [1:0] SRC_ME   = 2'd3;

endpackage

// File: rtl/redirect_select_t.sv
// rtl/redirect_select_t.sv - combinational priority pick among ME and the two EX redirect lanes
module redirect_select_t
    import redirect_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            me_req_i,
    input  logic [XLEN-1:0] me_target_i,
    input  logic            ex1_req_i,
    input  logic [XLEN-1:0] ex1_target_i,
    input  logic            ex2_req_i,
    input  logic [XLEN-1:0] ex2_target_i,
    input  logic            ex2_older_i,
    output logic [1:0]      src_o,
    output logic [XLEN-1:0] target_o,
    output logic            any_req_o
);

    // ME is oldest in flight; between EX lanes the older one wins, else whichever requests
    always_comb begin
        src_o    = SRC_NONE;
        target_o = '0;
        if (me_req_i) begin
            src_o    = SRC_ME;
            target_o = me_target_i;
        end else if (ex2_older_i && ex2_req_i) begin
            src_o    = SRC_EX2;
            target_o = ex2_target_i;
        end else if (ex1_req_i) begin
            src_o    = SRC_EX1;
            target_o = ex1_target_i;
        end else if (ex2_req_i) begin
            src_o    = SRC_EX2;
            target_o = ex2_target_i;
        end
    end

    assign any_req_o = (src_o != SRC_NONE);

endmodule

// File: rtl/redirect_control_t.sv
// rtl/redirect_control_t.sv - sequences one PC redirect into fetch, holding flush/stall, then drains
module redirect_control_t
    import redirect_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int DRAIN_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ACT,
    input  logic             s_me_pcsrc_Q,
    input  logic [XLEN-1:0]  s_me_target_Q,
    input  logic             s_ex1_pcsrc_Q,
    input  logic [XLEN-1:0]  s_ex1_target_Q,
    input  logic             s_ex2_pcsrc_Q,
    input  logic [XLEN-1:0]  s_ex2_target_Q,
    input  logic             s_ex2_older_Q,
    input  logic             redir_ready,
    output logic             redir_valid,
    output logic [XLEN-1:0]  redir_target,
    output logic             s_pipe_flush_D,
    output logic             s_if_stall_D,
    output logic [1:0]       redir_src,
    output logic [CNT_W-1:0] redir_count
);

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   target_q, target_d;
    logic [1:0]        src_q, src_d;
    logic [DW-1:0]     drain_q, drain_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [1:0]        sel_src;
    logic [XLEN-1:0]   sel_target;
    logic              sel_any;

    redirect_select_t #(.XLEN(XLEN)) u_select (
        .me_req_i     (s_me_pcsrc_Q),
        .me_target_i  (s_me_target_Q),
        .ex1_req_i    (s_ex1_pcsrc_Q),
        .ex1_target_i (s_ex1_target_Q),
        .ex2_req_i    (s_ex2_pcsrc_Q),
        .ex2_target_i (s_ex2_target_Q),
        .ex2_older_i  (s_ex2_older_Q),
        .src_o        (sel_src),
        .target_o     (sel_target),
        .any_req_o    (sel_any)
    );

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        src_d    = src_q;
        drain_d  = drain_q;
        count_d  = count_q;
        case (state_q)
            IDLE: begin
                if (ACT && sel_any) begin
                    state_d  = PEND;
                    target_d = {sel_target[XLEN-1:1], 1'b0};
                    src_d    = sel_src;
                end
            end
            PEND: begin
                // requests arriving here are on the wrong path and are deliberately dropped
                if (redir_ready) begin
                    state_d = DRAIN;
                    drain_d = DW'(DRAIN_CYCLES - 1);
                    if (count_q != {CNT_W{1'b1}}) begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (drain_q == '0) begin
                    state_d = IDLE;
                    src_d   = SRC_NONE;
                end else begin
                    drain_d = drain_q - DW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q  <= IDLE;
            target_q <= '0;
            src_q    <= SRC_NONE;
            drain_q  <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            src_q    <= src_d;
            drain_q  <= drain_d;
            count_q  <= count_d;
        end
    end

    assign redir_valid    = (state_q == PEND);
    assign s_if_stall_D   = (state_q == PEND);
    assign s_pipe_flush_D = (state_q != IDLE);
    assign redir_target   = target_q;
    assign redir_src      = src_q;
    assign redir_count    = count_q;

endmodule

// File: tb/tb_redirect_control_t.sv
// tb/tb_redirect_control_t.sv - scoreboard bench for redirect_control_t with directed redirect vectors
module tb_redirect_control_t;

    localparam int XLEN  = 32;
    localparam int DRAIN = 2;
    localparam int CNT_W = 2;

    typedef struct packed {
        logic [XLEN-1:0] target;
        logic [1:0]      src;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic             CLK, RST, ACT;
    logic             me_req, ex1_req, ex2_req, ex2_older, ready;
    logic [XLEN-1:0]  me_t, ex1_t, ex2_t;
    logic             redir_valid, flush, stall;
    logic [XLEN-1:0]  redir_target;
    logic [1:0]       redir_src;
    logic [CNT_W-1:0] redir_count;

    exp_t             sq[$];
    int               n_checks = 0;
    int               n_fail   = 0;
    int               post_cnt = 0;
    bit               check_idle = 0;
    logic [CNT_W-1:0] exp_cnt;
    logic [CNT_W-1:0] cnt_m;

    redirect_control_t #(.XLEN(XLEN), .DRAIN_CYCLES(DRAIN), .CNT_W(CNT_W)) dut (
        .CLK            (CLK),
        .RST            (RST),
        .ACT            (ACT),
        .s_me_pcsrc_Q   (me_req),
        .s_me_target_Q  (me_t),
        .s_ex1_pcsrc_Q  (ex1_req),
        .s_ex1_target_Q (ex1_t),
        .s_ex2_pcsrc_Q  (ex2_req),
        .s_ex2_target_Q (ex2_t),
        .s_ex2_older_Q  (ex2_older),
        .redir_ready    (ready),
        .redir_valid    (redir_valid),
        .redir_target   (redir_target),
        .s_pipe_flush_D (flush),
        .s_if_stall_D   (stall),
        .redir_src      (redir_src),
        .redir_count    (redir_count)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: compares offered redirects against the scoreboard and tracks the drain window
    always @(negedge CLK) begin
        if (!RST) begin
            sq.delete();
            post_cnt   = 0;
            check_idle = 0;
        end else if (post_cnt > 0) begin
            chk("drain_flush", {31'd0, flush}, 32'd1);
            chk("drain_stall", {31'd0, stall}, 32'd0);
            chk("drain_valid", {31'd0, redir_valid}, 32'd0);
            if (post_cnt == DRAIN) chk("count", {30'd0, redir_count}, {30'd0, exp_cnt});
            post_cnt--;
            if (post_cnt == 0) check_idle = 1;
        end else if (check_idle) begin
            chk("idle_flush", {31'd0, flush}, 32'd0);
            chk("idle_src", {30'd0, redir_src}, 32'd0);
            check_idle = 0;
        end else if (redir_valid) begin
            if (sq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_valid: got target 0x%0h src %0d, expected no redirect", redir_target, redir_src);
            end else begin
                chk("target", redir_target, sq[0].target);
                chk("src", {30'd0, redir_src}, {30'd0, sq[0].src});
                chk("pend_flush", {31'd0, flush}, 32'd1);
                chk("pend_stall", {31'd0, stall}, 32'd1);
                if (ready) begin
                    exp_cnt  = sq[0].cnt;
                    void'(sq.pop_front());
                    post_cnt = DRAIN;
                end
            end
        end
    end

    task automatic clear_inputs();
        ACT = 1'b0; me_req = 1'b0; ex1_req = 1'b0; ex2_req = 1'b0; ex2_older = 1'b0;
        me_t = '0; ex1_t = '0; ex2_t = '0;
    endtask

    task automatic issue(input logic me, input logic [31:0] mt, input logic e1, input logic [31:0] t1,
                         input logic e2, input logic [31:0] t2, input logic older,
                         input logic [31:0] et, input logic [1:0] es);
        exp_t e;
        cnt_m    = (cnt_m == {CNT_W{1'b1}}) ? cnt_m : cnt_m + 1'b1;
        e.target = et;
        e.src    = es;
        e.cnt    = cnt_m;
        sq.push_back(e);
        @(posedge CLK); #1;
        ACT = 1'b1; me_req = me; me_t = mt; ex1_req = e1; ex1_t = t1;
        ex2_req = e2; ex2_t = t2; ex2_older = older;
        @(posedge CLK); #1;
        clear_inputs();
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while (!(sq.size() == 0 && post_cnt == 0 && !check_idle) && n < 40) begin
            @(posedge CLK); #1;
            n++;
        end
        n_checks++;
        if (n >= 40) begin
            n_fail++;
            $display("FAIL %s_timeout: redirect not completed after %0d cycles, expected completion", nm, n);
        end
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, "_valid"}, {31'd0, redir_valid}, 32'd0);
        chk({nm, "_target"}, redir_target, 32'd0);
        chk({nm, "_flush"}, {31'd0, flush}, 32'd0);
        chk({nm, "_stall"}, {31'd0, stall}, 32'd0);
        chk({nm, "_src"}, {30'd0, redir_src}, 32'd0);
        chk({nm, "_count"}, {30'd0, redir_count}, 32'd0);
    endtask

    initial begin
        clear_inputs();
        RST   = 1'b0;
        ready = 1'b1;
        cnt_m = '0;
        repeat (3) @(posedge CLK);
        #1;
        check_reset_outputs("reset");
        RST = 1'b1;

        // ACT=0 in IDLE: request must not be captured
        @(posedge CLK); #1;
        ex1_req = 1'b1; ex1_t = 32'h0000_0ABC;
        @(posedge CLK); #1;
        clear_inputs();
        repeat (3) @(posedge CLK);
        #1;

        issue(1'b0, 32'h0, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h100, 2'd1);
        wait_done("t1");
        issue(1'b1, 32'h80, 1'b1, 32'h400, 1'b0, 32'h0, 1'b0, 32'h80, 2'd3);
        wait_done("t3");
        issue(1'b0, 32'h0, 1'b1, 32'h200, 1'b1, 32'h300, 1'b1, 32'h300, 2'd2);
        wait_done("t2a");
        issue(1'b0, 32'h0, 1'b1, 32'h200, 1'b1, 32'h300, 1'b0, 32'h200, 2'd1);
        wait_done("t2b");

        // ready held low: offer stays stable, a new request mid-PEND is dropped
        ready = 1'b0;
        issue(1'b0, 32'h0, 1'b1, 32'h600, 1'b0, 32'h0, 1'b0, 32'h600, 2'd1);
        ACT = 1'b1; ex2_req = 1'b1; ex2_t = 32'h500;
        @(posedge CLK); #1;
        clear_inputs();
        repeat (4) @(posedge CLK);
        #1;
        ready = 1'b1;
        wait_done("t4");
        repeat (3) @(posedge CLK);
        #1;

        // odd target is aligned; reset during PEND clears everything at the next edge
        ready = 1'b0;
        issue(1'b0, 32'h0, 1'b1, 32'h1235, 1'b0, 32'h0, 1'b0, 32'h1234, 2'd1);
        repeat (2) @(posedge CLK);
        #1;
        RST   = 1'b0;
        ready = 1'b1;
        @(posedge CLK); #1;
        check_reset_outputs("midreset");
        RST   = 1'b1;
        cnt_m = '0;
        repeat (2) @(posedge CLK);
        #1;

        // counter saturation with younger-lane fallbacks
        issue(1'b0, 32'h0, 1'b1, 32'h700, 1'b0, 32'h0, 1'b1, 32'h700, 2'd1);
        wait_done("t6a");
        issue(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h800, 1'b0, 32'h800, 2'd2);
        wait_done("t6b");
        issue(1'b1, 32'h901, 1'b0, 32'h0, 1'b1, 32'h904, 1'b1, 32'h900, 2'd3);
        wait_done("t6c");
        issue(1'b0, 32'h0, 1'b1, 32'hA00, 1'b1, 32'hB00, 1'b0, 32'hA00, 2'd1);
        wait_done("t6d");
        chk("final_count", {30'd0, redir_count}, 32'd3);

        repeat (3) @(posedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
